bsg_id_pool_share: RTL and testbench

Controller that shares one ID pool between `num_req_p` requesters. It is a round-robin arbiter with per-requester reservations, and sits directly in front of the pool's alloc/dealloc ports. It tracks which requester owns each outstanding ID and how many IDs each requester holds. It guarantees every requester `reserve_p` IDs, so one greedy requester can never drain the whole pool.

---
 rtl/bsg_id_pool_share.sv | 127 ++++++++++++
 tb/tb_bsg_id_pool_share.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bsg_id_pool_share.sv
// rtl/bsg_id_pool_share.sv - round-robin ID pool sharing with per-requester reservations
module bsg_id_pool_share #(
    parameter int els_p        = 8,
    parameter int num_req_p    = 3,
    parameter int reserve_p    = 1,
    parameter int id_width_lp  = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int req_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [num_req_p-1:0]    req_v_i,
    output logic [num_req_p-1:0]    grant_o,
    output logic [id_width_lp-1:0]  grant_id_o,
    input  logic                    pool_v_i,
    input  logic [id_width_lp-1:0]  pool_id_i,
    output logic                    pool_yumi_o,
    input  logic                    dealloc_v_i,
    input  logic [id_width_lp-1:0]  dealloc_id_i,
    output logic                    pool_dealloc_v_o,
    output logic [id_width_lp-1:0]  pool_dealloc_id_o
);

    localparam int count_width_lp = $clog2(els_p + 1);

    logic [count_width_lp-1:0] count_r [num_req_p];
    logic [count_width_lp-1:0] free_r;
    logic [req_width_lp-1:0]   owner_r [els_p];
    logic [req_width_lp-1:0]   rr_r;
    logic [els_p-1:0]          live_r;
    logic [els_p-1:0]          live_next;

    int                        owed;
    logic                      surplus;
    logic [num_req_p-1:0]      elig;
    logic [req_width_lp-1:0]   grant_idx;
    logic                      grant_v;
    logic [req_width_lp-1:0]   dealloc_owner;

    // IDs still owed to requesters below their reservation; only the excess is open to anyone
    always_comb begin
        owed = 0;
        for (int r = 0; r < num_req_p; r++) begin
            if (int'(count_r[r]) < reserve_p) owed = owed + reserve_p - int'(count_r[r]);
        end
    end

    assign surplus = int'(free_r) > owed;

    always_comb begin
        elig = '0;
        for (int r = 0; r < num_req_p; r++) begin
            elig[r] = req_v_i[r] & pool_v_i & ~reset_i
                    & ((int'(count_r[r]) < reserve_p) | surplus);
        end
    end

    // Lowest eligible index at or above rr_r overrides the lowest eligible index overall
    always_comb begin
        grant_v   = |elig;
        grant_idx = '0;
        for (int r = num_req_p - 1; r >= 0; r--) begin
            if (elig[r]) grant_idx = req_width_lp'(r);
        end
        for (int r = num_req_p - 1; r >= 0; r--) begin
            if (elig[r] && r >= int'(rr_r)) grant_idx = req_width_lp'(r);
        end
    end

    always_comb begin
        grant_o = '0;
        for (int r = 0; r < num_req_p; r++) begin
            grant_o[r] = grant_v && (grant_idx == req_width_lp'(r));
        end
    end

    assign grant_id_o        = pool_id_i;
    assign pool_yumi_o       = grant_v;
    assign pool_dealloc_v_o  = dealloc_v_i;
    assign pool_dealloc_id_o = dealloc_id_i;
    assign dealloc_owner     = owner_r[dealloc_id_i];

    always_comb begin
        live_next = live_r;
        if (dealloc_v_i) live_next[dealloc_id_i] = 1'b0;
        if (grant_v)     live_next[pool_id_i]    = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int r = 0; r < num_req_p; r++) count_r[r] <= '0;
            free_r <= count_width_lp'(els_p);
            rr_r   <= '0;
            live_r <= '0;
        end else begin
            for (int r = 0; r < num_req_p; r++) begin
                count_r[r] <= count_r[r]
                            + count_width_lp'(grant_v && (grant_idx == req_width_lp'(r)))
                            - count_width_lp'(dealloc_v_i && (dealloc_owner == req_width_lp'(r)));
            end
            free_r <= free_r + count_width_lp'(dealloc_v_i) - count_width_lp'(grant_v);
            if (grant_v) rr_r <= (grant_idx == req_width_lp'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;
            live_r <= live_next;
        end
    end

    // Owner write happens after the dealloc lookup, so a same-cycle re-issue keeps the new owner
    always_ff @(posedge clk_i) begin
        if (grant_v) owner_r[pool_id_i] <= grant_idx;
    end

    dealloc_of_live_id: assert property (@(posedge clk_i) disable iff (reset_i)
        dealloc_v_i |-> live_r[dealloc_id_i]);

    free_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
        !(dealloc_v_i && !grant_v && free_r == count_width_lp'(els_p))
        && !(grant_v && !dealloc_v_i && free_r == '0));

    for (genvar g = 0; g < num_req_p; g++) begin : g_count_chk
        count_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
            !(dealloc_v_i && dealloc_owner == req_width_lp'(g)
              && !(grant_v && grant_idx == req_width_lp'(g)) && count_r[g] == '0)
            && !(grant_v && grant_idx == req_width_lp'(g)
              && !(dealloc_v_i && dealloc_owner == req_width_lp'(g))
              && count_r[g] == count_width_lp'(els_p)));
    end

endmodule

// File: tb/tb_bsg_id_pool_share.sv
// tb/tb_bsg_id_pool_share.sv - scoreboard bench for bsg_id_pool_share (reserve 2 and reserve 0)
module tb_bsg_id_pool_share;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, pv_a, dv_a, yumi_a, pdv_a;
    logic [2:0] req_a, grant_a, pid_a, did_a, gid_a, pdid_a;
    logic       rst_b, pv_b, dv_b, yumi_b, pdv_b;
    logic [2:0] req_b, grant_b, pid_b, did_b, gid_b, pdid_b;

    bsg_id_pool_share #(.els_p(8), .num_req_p(3), .reserve_p(2)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .req_v_i(req_a), .grant_o(grant_a), .grant_id_o(gid_a),
        .pool_v_i(pv_a), .pool_id_i(pid_a), .pool_yumi_o(yumi_a),
        .dealloc_v_i(dv_a), .dealloc_id_i(did_a),
        .pool_dealloc_v_o(pdv_a), .pool_dealloc_id_o(pdid_a)
    );

    bsg_id_pool_share #(.els_p(8), .num_req_p(3), .reserve_p(0)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .req_v_i(req_b), .grant_o(grant_b), .grant_id_o(gid_b),
        .pool_v_i(pv_b), .pool_id_i(pid_b), .pool_yumi_o(yumi_b),
        .dealloc_v_i(dv_b), .dealloc_id_i(did_b),
        .pool_dealloc_v_o(pdv_b), .pool_dealloc_id_o(pdid_b)
    );

    typedef struct { int r; int id; } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // exp_r < 0 means no grant is expected this cycle
    task automatic step(input int inst, input logic rst, input logic [2:0] req, input logic pv,
                        input int pid, input logic dv, input int did, input int exp_r);
        @(posedge clk);
        #1;
        if (inst == 0) begin
            rst_a = rst; req_a = req; pv_a = pv; pid_a = 3'(pid); dv_a = dv; did_a = 3'(did);
            if (exp_r >= 0) q_a.push_back('{r: exp_r, id: pid});
        end else begin
            rst_b = rst; req_b = req; pv_b = pv; pid_b = 3'(pid); dv_b = dv; did_b = 3'(did);
            if (exp_r >= 0) q_b.push_back('{r: exp_r, id: pid});
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (grant_a != 3'b000) begin
            if (q_a.size() == 0) chk("a_unexpected_grant", int'(grant_a), 0);
            else begin
                e = q_a.pop_front();
                chk("a_grant", int'(grant_a), 1 << e.r);
                chk("a_grant_id", int'(gid_a), e.id);
            end
        end
        chk("a_yumi", int'(yumi_a), int'(grant_a != 3'b000));
        chk("a_missing_grant", q_a.size(), 0);
        if (dv_a) chk("a_dealloc_pass", int'({pdv_a, pdid_a}), int'({1'b1, did_a}));
        if (grant_b != 3'b000) begin
            if (q_b.size() == 0) chk("b_unexpected_grant", int'(grant_b), 0);
            else begin
                e = q_b.pop_front();
                chk("b_grant", int'(grant_b), 1 << e.r);
                chk("b_grant_id", int'(gid_b), e.id);
            end
        end
        chk("b_yumi", int'(yumi_b), int'(grant_b != 3'b000));
        chk("b_missing_grant", q_b.size(), 0);
    end

    initial begin
        rst_a = 1'b1; req_a = '0; pv_a = 1'b0; pid_a = '0; dv_a = 1'b0; did_a = '0;
        rst_b = 1'b1; req_b = '0; pv_b = 1'b0; pid_b = '0; dv_b = 1'b0; did_b = '0;

        // full contention: grants held off during reset, then strict rotation
        step(0, 1, 3'b111, 1, 0, 0, 0, -1);
        step(0, 1, 3'b111, 1, 0, 0, 0, -1);
        for (int i = 0; i < 8; i++) step(0, 0, 3'b111, 1, i, 0, 0, i % 3);
        step(0, 0, 3'b111, 0, 0, 0, 0, -1);
        chk("contention_free", int'(dut_a.free_r), 0);
        chk("contention_cnt0", int'(dut_a.count_r[0]), 3);
        chk("contention_cnt2", int'(dut_a.count_r[2]), 2);

        // reserve protection and credit return
        step(0, 1, 3'b000, 0, 0, 0, 0, -1);
        for (int i = 0; i < 4; i++) step(0, 0, 3'b001, 1, i, 0, 0, 0);
        step(0, 0, 3'b001, 1, 4, 0, 0, -1);
        step(0, 0, 3'b001, 1, 4, 1, 1, -1);
        chk("stall_free", int'(dut_a.free_r), 4);
        chk("stall_cnt0", int'(dut_a.count_r[0]), 4);
        step(0, 0, 3'b001, 1, 1, 0, 0, 0);
        step(0, 0, 3'b011, 1, 4, 0, 0, 1);
        chk("credit_free", int'(dut_a.free_r), 4);
        chk("credit_cnt0", int'(dut_a.count_r[0]), 4);
        step(0, 0, 3'b000, 0, 0, 0, 0, -1);
        chk("reserve_cnt1", int'(dut_a.count_r[1]), 1);
        chk("reserve_free", int'(dut_a.free_r), 3);

        // same-cycle recycle of ID 2 from r1 to r2
        step(0, 1, 3'b000, 0, 0, 0, 0, -1);
        step(0, 0, 3'b010, 1, 2, 0, 0, 1);
        step(0, 0, 3'b100, 1, 2, 1, 2, 2);
        step(0, 0, 3'b000, 0, 0, 0, 0, -1);
        chk("recycle_owner2", int'(dut_a.owner_r[2]), 2);
        chk("recycle_cnt1", int'(dut_a.count_r[1]), 0);
        chk("recycle_cnt2", int'(dut_a.count_r[2]), 1);
        chk("recycle_free", int'(dut_a.free_r), 7);

        // reset with five IDs outstanding
        step(0, 0, 3'b111, 1, 0, 0, 0, 0);
        step(0, 0, 3'b111, 1, 1, 0, 0, 1);
        step(0, 0, 3'b111, 1, 3, 0, 0, 2);
        step(0, 0, 3'b111, 1, 4, 0, 0, 0);
        step(0, 1, 3'b111, 1, 5, 0, 0, -1);
        chk("premid_free", int'(dut_a.free_r), 3);
        chk("premid_rr", int'(dut_a.rr_r), 1);
        step(0, 0, 3'b111, 1, 0, 0, 0, 0);
        chk("postrst_free", int'(dut_a.free_r), 8);
        chk("postrst_cnt0", int'(dut_a.count_r[0]), 0);
        chk("postrst_cnt1", int'(dut_a.count_r[1]), 0);
        chk("postrst_cnt2", int'(dut_a.count_r[2]), 0);
        chk("postrst_rr", int'(dut_a.rr_r), 0);
        step(0, 0, 3'b000, 0, 0, 0, 0, -1);

        // reserve 0: one requester drains the pool, then plain round robin
        step(1, 1, 3'b000, 0, 0, 0, 0, -1);
        for (int i = 0; i < 8; i++) step(1, 0, 3'b001, 1, i, 0, 0, 0);
        step(1, 0, 3'b001, 1, 0, 0, 0, -1);
        step(1, 0, 3'b000, 0, 0, 0, 0, -1);
        chk("r0_free", int'(dut_b.free_r), 0);
        chk("r0_cnt0", int'(dut_b.count_r[0]), 8);
        step(1, 1, 3'b000, 0, 0, 0, 0, -1);
        step(1, 0, 3'b111, 1, 0, 0, 0, 0);
        step(1, 0, 3'b111, 1, 1, 0, 0, 1);
        step(1, 0, 3'b111, 1, 2, 0, 0, 2);
        step(1, 0, 3'b111, 1, 3, 0, 0, 0);
        step(1, 0, 3'b101, 1, 4, 0, 0, 2);
        step(1, 0, 3'b101, 1, 5, 0, 0, 0);
        step(1, 0, 3'b110, 1, 6, 0, 0, 1);
        step(1, 0, 3'b000, 0, 0, 0, 0, -1);
        chk("rr_ptr", int'(dut_b.rr_r), 2);
        chk("rr_free", int'(dut_b.free_r), 1);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
